kaipokrandt_memarb: RTL and testbench
=====================================

# kaipokrandt_memarb

Two-port arbiter that shares the single `kaipokrandt_bmem` instance between the CPU top level (port 0) and a second bus master such as a program loader or DMA (port 1). It accepts enable-style requests with the same EN/RW/address/data/MFC handshake the bmem exposes, and serialises them onto the memory. It returns data and a one-cycle MFC pulse to the winning requester, and enforces a dead-memory timeout.

## Interface
- `AW`, 16: address width.
- `DW`, 16: data width.
- `TIMEOUT`, 255: maximum cycles spent in BUSY waiting for `mem_MFC` (1..255).

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `r0_EN`, `r1_EN`  in  1  request enable, held high until the matching MFC pulse.
- `r0_RW`, `r1_RW`  in  1  read/write; bmem encoding, passed through unchanged.
- `r0_addr`, `r1_addr`  in  AW  request address.
- `r0_wdata`, `r1_wdata`  in  DW  write data.
- `r0_MFC`, `r1_MFC`  out  1  one-cycle completion pulse.
- `rdata`  out  DW  read data, shared by both ports; valid in the MFC cycle.
- `err`  out  1  one-cycle pulse, coincident with MFC, when the access timed out.
- `gnt`  out  2  one-hot current owner; 2'b00 when idle.
- `mem_EN`, `mem_RW`, `mem_addr`, `mem_datain`  out  to bmem `enable`/`readwrite`/`address`/`datain`.
- `mem_dataout`, `mem_MFC`  in  from bmem `dataout`/`MFC`.

## Operation
- FSM states: IDLE, BUSY, DONE, GAP. All outputs are registered.
- **IDLE**
  - Sample `r0_EN`/`r1_EN`.
  - On any request:
    - latch the winner's RW/addr/wdata into the `mem_*` registers;
    - set `gnt`;
    - set `mem_EN`=1;
    - clear the timeout counter;
    - go to BUSY.
- **Arbitration**
  - Fixed priority: port 0 beats port 1 on a simultaneous request.
  - A lone requester always wins.
- **BUSY**
  - `mem_EN` held at 1. The `mem_*` address, RW and data registers stay frozen; changes on the requester inputs are ignored.
  - Counter increments each cycle.
  - On `mem_MFC`=1:
    - capture `mem_dataout` into `rdata` (for reads and writes alike);
    - go to DONE.
  - If the counter reaches `TIMEOUT` without `mem_MFC`:
    - `rdata`=0;
    - set the timeout flag;
    - go to DONE.
  - `mem_MFC` wins over timeout if both occur in the same cycle.
- **DONE** (one cycle)
  - `mem_EN`=0.
  - The owner's `rX_MFC`=1.
  - `err`=timeout flag.
  - `gnt` still shows the owner.
  - Go to GAP.
- **GAP** (one cycle)
  - `mem_EN`=0; `gnt`=0.
  - No request sampling. This gives the requester time to drop EN and the bmem time to re-arm.
  - Go to IDLE.
- **Reset**, including mid-transfer, takes effect at the next `clk` edge:
  - state IDLE;
  - `mem_EN`/`mem_RW`=0;
  - `mem_addr`/`mem_datain`/`rdata`=0;
  - `gnt`=0;
  - `r0_MFC`/`r1_MFC`/`err`=0;
  - counter=0;
  - round-robin pointer (when enabled) = "port 0 preferred".
  - No MFC pulse is issued for the aborted access.
- **Requester obligations:**
  - EN is held high until MFC.
  - EN is deasserted no later than the cycle after MFC.
  - An EN still high in IDLE is treated as a new request.

## Timing
- Request seen at edge N → `mem_EN`=1 from N+1.
- `mem_MFC` sampled high at edge M → `rX_MFC`/`rdata` valid in cycle M+1, `mem_EN`=0 from M+1.
- Re-arbitration at edge M+3 (DONE at M+1, GAP at M+2, IDLE sampling at M+3).
- Minimum access: 4 cycles per transfer when the bmem responds one cycle after enable.
- Back-to-back throughput is bounded by the GAP cycle.
- Timeout: the DONE/err pulse occurs `TIMEOUT`+1 cycles after `mem_EN` rose.

## Configuration
- `KAIPOKRANDT_ARB_RR_EN`
  - Defined: round-robin. A 1-bit pointer records the last served port. On a simultaneous request the other port wins. The pointer updates on entry to DONE, for timeouts as well as normal completion.
  - Undefined: fixed priority, port 0 always wins. No pointer register is built.

## Test plan
- **Single read:** port 0 only, `r0_EN`=1, read RW, addr 16'h0003, bmem word = 16'h0011.
  - `r0_MFC` pulses once with `rdata`=16'h0011.
  - `r1_MFC` stays 0; `gnt` 2'b01 → 2'b00.
- **Write then read-back:** port 1 writes 16'hF0F0 to 16'h0010, then reads 16'h0010.
  - Second access returns `rdata`=16'hF0F0.
  - `mem_EN` is 0 for at least 2 cycles between the two accesses.
- **Simultaneous requests:** both ports request at once, each repeating 3 times (port 0 at addr 16'h0000, port 1 at 16'h0001).
  - Without the macro: grant order 0,0,0,1,1,1.
  - With `KAIPOKRANDT_ARB_RR_EN`: grant order 0,1,0,1,0,1.
- **Timeout:** `TIMEOUT`=8, bmem replaced by a stub that never asserts MFC.
  - `r0_MFC` and `err` pulse together 9 cycles after `mem_EN` rose.
  - `rdata`=0; the next request is serviced normally.
- **Reset mid-transfer:** `reset`=1 for 1 cycle while in BUSY.
  - Next cycle: `mem_EN`=0, `gnt`=0, all outputs at reset values.
  - No MFC pulse; a new port 1 request is granted afterwards.
- **Mid-access input change:** `r0_addr` changes during BUSY.
  - `mem_addr` keeps the latched value until DONE.

Source files
------------

// File: rtl/kaipokrandt_memarb_if.sv
// kaipokrandt_memarb_if
// Enable-style memory bus: EN/RW/address/write-data from the initiator, read
// data and a completion pulse (MFC) back from the target. The same bus type
// connects each requester to the arbiter and the arbiter to the bmem.
//   EN     initiator -> target  request enable, held until MFC
//   RW     initiator -> target  read/write, bmem encoding
//   addr   initiator -> target  AW-bit address
//   wdata  initiator -> target  DW-bit write data (bmem datain)
//   rdata  target -> initiator  DW-bit read data (bmem dataout)
//   MFC    target -> initiator  completion
// Modports: master = initiator side, slave = target side.
interface kaipokrandt_memarb_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          EN;
  logic          RW;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          MFC;

  modport master (output EN, RW, addr, wdata, input rdata, MFC);
  modport slave  (input EN, RW, addr, wdata, output rdata, MFC);
endinterface

// File: rtl/kaipokrandt_memarb.sv
// kaipokrandt_memarb
// Shares one bmem between two requesters (port 0 = CPU, port 1 = loader/DMA).
// Requests are serialised through IDLE -> BUSY -> DONE -> GAP; a dead memory
// is abandoned after TIMEOUT cycles in BUSY and reported with err.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   r0     slave  bus from requester 0 (rdata shared by both requesters)
//   r1     slave  bus from requester 1
//   mem    master bus to the bmem
//   err    out  one-cycle timeout pulse, coincident with the owner's MFC
//   gnt    out  one-hot owner, 2'b00 when idle
// Optional feature: define KAIPOKRANDT_ARB_RR_EN for round-robin arbitration
// on simultaneous requests; otherwise port 0 always wins.
module kaipokrandt_memarb #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  kaipokrandt_memarb_if.slave   r0,
  kaipokrandt_memarb_if.slave   r1,
  kaipokrandt_memarb_if.master  mem,
  output logic                  err,
  output logic [1:0]            gnt
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_GAP} state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  state_t        r_state, w_state;
  logic          r_mem_en, w_mem_en;
  logic          r_mem_rw, w_mem_rw;
  logic [AW-1:0] r_mem_addr, w_mem_addr;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata;
  logic [DW-1:0] r_rdata, w_rdata;
  logic [1:0]    r_mfc, w_mfc;
  logic          r_err, w_err;
  logic [1:0]    r_gnt, w_gnt;
  logic [7:0]    r_cnt, w_cnt;
  logic          w_pick1;
  logic          w_done_entry;

`ifdef KAIPOKRANDT_ARB_RR_EN
  // r_last_p1 = 1 means port 1 was served last, so port 0 is preferred next.
  logic r_last_p1;

  // Pointer update on every entry to DONE (completion or timeout).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_p1 <= 1'b1;
    end else if (w_done_entry) begin
      r_last_p1 <= r_gnt[1];
    end else begin
      r_last_p1 <= r_last_p1;
    end
  end

  assign w_pick1 = r1.EN & (~r0.EN | ~r_last_p1);
`else
  assign w_pick1 = r1.EN & ~r0.EN;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    w_state      = r_state;
    w_mem_en     = r_mem_en;
    w_mem_rw     = r_mem_rw;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_rdata      = r_rdata;
    w_mfc        = 2'b00;
    w_err        = 1'b0;
    w_gnt        = r_gnt;
    w_cnt        = r_cnt;
    w_done_entry = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r0.EN | r1.EN) begin
          w_state  = S_BUSY;
          w_mem_en = 1'b1;
          w_cnt    = 8'd0;
          if (w_pick1) begin
            w_gnt       = 2'b10;
            w_mem_rw    = r1.RW;
            w_mem_addr  = r1.addr;
            w_mem_wdata = r1.wdata;
          end else begin
            w_gnt       = 2'b01;
            w_mem_rw    = r0.RW;
            w_mem_addr  = r0.addr;
            w_mem_wdata = r0.wdata;
          end
        end else begin
          w_gnt = 2'b00;
        end
      end
      S_BUSY: begin
        w_cnt = r_cnt + 8'd1;
        // MFC is checked first so it wins over a coincident timeout.
        if (mem.MFC) begin
          w_state      = S_DONE;
          w_mem_en     = 1'b0;
          w_rdata      = mem.rdata;
          w_mfc        = r_gnt;
          w_done_entry = 1'b1;
        end else if (r_cnt == LP_TIMEOUT) begin
          w_state      = S_DONE;
          w_mem_en     = 1'b0;
          w_rdata      = {DW{1'b0}};
          w_mfc        = r_gnt;
          w_err        = 1'b1;
          w_done_entry = 1'b1;
        end else begin
          w_state = S_BUSY;
        end
      end
      S_DONE: begin
        w_state = S_GAP;
        w_gnt   = 2'b00;
      end
      S_GAP: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state  = S_IDLE;
        w_mem_en = 1'b0;
        w_gnt    = 2'b00;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_en    <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_addr  <= {AW{1'b0}};
      r_mem_wdata <= {DW{1'b0}};
      r_rdata     <= {DW{1'b0}};
      r_mfc       <= 2'b00;
      r_err       <= 1'b0;
      r_gnt       <= 2'b00;
      r_cnt       <= 8'd0;
    end else begin
      r_mem_en    <= w_mem_en;
      r_mem_rw    <= w_mem_rw;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_rdata     <= w_rdata;
      r_mfc       <= w_mfc;
      r_err       <= w_err;
      r_gnt       <= w_gnt;
      r_cnt       <= w_cnt;
    end
  end

  assign mem.EN    = r_mem_en;
  assign mem.RW    = r_mem_rw;
  assign mem.addr  = r_mem_addr;
  assign mem.wdata = r_mem_wdata;
  assign r0.MFC    = r_mfc[0];
  assign r1.MFC    = r_mfc[1];
  assign r0.rdata  = r_rdata;
  assign r1.rdata  = r_rdata;
  assign err       = r_err;
  assign gnt       = r_gnt;

endmodule

// File: tb/tb_kaipokrandt_memarb.sv
// Testbench for kaipokrandt_memarb: behavioural bmem (MFC one cycle after
// EN, or never when mem_dead is set), directed requests on both ports, and a
// scoreboard monitor that checks every MFC pulse against queued expectations.
module tb_kaipokrandt_memarb;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  typedef struct packed {
    logic [1:0]  port;
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        err;
  logic [1:0]  gnt;
  logic        mem_dead;
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          low_run;
  int          last_low_run;
  logic        prev_en;
  logic [15:0] marr [0:255];
  exp_t        sb_q [$];

  kaipokrandt_memarb_if #(.AW(16), .DW(16)) r0_if ();
  kaipokrandt_memarb_if #(.AW(16), .DW(16)) r1_if ();
  kaipokrandt_memarb_if #(.AW(16), .DW(16)) mem_if ();

  kaipokrandt_memarb #(.AW(16), .DW(16), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .r0    (r0_if),
    .r1    (r1_if),
    .mem   (mem_if),
    .err   (err),
    .gnt   (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural bmem.
  always @(posedge clk) begin
    if (reset) begin
      mem_if.MFC   <= 1'b0;
      mem_if.rdata <= 16'h0000;
    end else if (mem_if.EN && !mem_dead) begin
      if (!mem_if.MFC) begin
        if (mem_if.RW == WR) begin
          marr[mem_if.addr[7:0]] <= mem_if.wdata;
          mem_if.rdata           <= mem_if.wdata;
        end else begin
          mem_if.rdata <= marr[mem_if.addr[7:0]];
        end
        mem_if.MFC <= 1'b1;
      end
    end else begin
      mem_if.MFC <= 1'b0;
    end
  end

  // Length of the most recent mem_EN low stretch before a rising edge.
  always @(negedge clk) begin
    if (mem_if.EN) begin
      if (!prev_en) last_low_run <= low_run;
      low_run <= 0;
    end else begin
      low_run <= low_run + 1;
    end
    prev_en <= mem_if.EN;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (r0_if.MFC || r1_if.MFC) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_mfc: got mfc=%b, expected none (cycle %0d)",
                   {r1_if.MFC, r0_if.MFC}, cyc);
        end else begin
          e = sb_q.pop_front();
          check("mfc_port", {30'd0, r1_if.MFC, r0_if.MFC}, {30'd0, e.port});
          check("rdata_port0", {16'd0, r0_if.rdata}, {16'd0, e.data});
          check("rdata_port1", {16'd0, r1_if.rdata}, {16'd0, e.data});
          check("err", {31'd0, err}, {31'd0, e.err});
        end
      end else if (err) begin
        n_checks++;
        n_fail++;
        $display("FAIL err_without_mfc: got err=1, expected 0 (cycle %0d)", cyc);
      end
    end
  end

  task automatic set_req(input int port, input logic en, input logic rw,
                         input logic [15:0] addr, input logic [15:0] wd);
    if (port == 0) begin
      r0_if.EN = en; r0_if.RW = rw; r0_if.addr = addr; r0_if.wdata = wd;
    end else begin
      r1_if.EN = en; r1_if.RW = rw; r1_if.addr = addr; r1_if.wdata = wd;
    end
  endtask

  function automatic logic mfc_of(input int port);
    return (port == 0) ? r0_if.MFC : r1_if.MFC;
  endfunction

  task automatic do_req(input int port, input logic rw, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [15:0] exp_data,
                        input logic push, input logic chk_gnt);
    int n;
    if (push) sb_q.push_back(exp_t'{(port == 0) ? 2'b01 : 2'b10, exp_data, 1'b0});
    @(posedge clk); #1;
    set_req(port, 1'b1, rw, addr, wd);
    if (chk_gnt) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_if.EN && n < 50);
      check("gnt_busy", {30'd0, gnt}, (port == 0) ? 32'd1 : 32'd2);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!mfc_of(port) && n < 400);
    if (!mfc_of(port)) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_mfc: got no MFC on port %0d, expected one", port);
    end
    set_req(port, 1'b0, rw, addr, wd);
    if (chk_gnt) begin
      @(negedge clk);
      check("gnt_gap", {30'd0, gnt}, 32'd0);
    end
  endtask

  initial begin
    int n;
    int t0;
    n_checks = 0; n_fail = 0; cyc = 0;
    low_run = 0; last_low_run = 0; prev_en = 1'b0;
    mem_dead = 1'b0;
    reset = 1'b1;
    set_req(0, 1'b0, RD, 16'h0000, 16'h0000);
    set_req(1, 1'b0, RD, 16'h0000, 16'h0000);
    for (int i = 0; i < 256; i++) marr[i] = 16'h0000;
    marr[0] = 16'hA000;
    marr[1] = 16'hB001;
    marr[3] = 16'h0011;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_mem_en", {31'd0, mem_if.EN}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_if.addr}, 32'd0);
    check("rst_rdata", {16'd0, r0_if.rdata}, 32'd0);
    check("rst_mfc", {30'd0, r1_if.MFC, r0_if.MFC}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Single read on port 0.
    do_req(0, RD, 16'h0003, 16'h0000, 16'h0011, 1'b1, 1'b1);

    // Port 1 write then read-back, with the idle gap between them.
    do_req(1, WR, 16'h0010, 16'hF0F0, 16'hF0F0, 1'b1, 1'b1);
    do_req(1, RD, 16'h0010, 16'h0000, 16'hF0F0, 1'b1, 1'b1);
    check("en_gap_ge2", {31'd0, (last_low_run >= 2)}, 32'd1);

    // Simultaneous requests, three each.
`ifdef KAIPOKRANDT_ARB_RR_EN
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(exp_t'{2'b01, 16'hA000, 1'b0});
      sb_q.push_back(exp_t'{2'b10, 16'hB001, 1'b0});
    end
`else
    for (int i = 0; i < 3; i++) sb_q.push_back(exp_t'{2'b01, 16'hA000, 1'b0});
    for (int i = 0; i < 3; i++) sb_q.push_back(exp_t'{2'b10, 16'hB001, 1'b0});
`endif
    fork
      begin
        for (int i = 0; i < 3; i++) do_req(0, RD, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
      end
      begin
        for (int j = 0; j < 3; j++) do_req(1, RD, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0);
      end
    join

    // Timeout with a dead bmem; r0_addr changes mid-access.
    mem_dead = 1'b1;
    sb_q.push_back(exp_t'{2'b01, 16'h0000, 1'b1});
    @(posedge clk); #1;
    set_req(0, 1'b1, RD, 16'h0005, 16'h0000);
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_if.EN && n < 50);
    t0 = cyc;
    r0_if.addr = 16'h0077;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("addr_frozen", {16'd0, mem_if.addr}, 32'h0005);
    end
    n = 0;
    while (!r0_if.MFC && n < 50) begin @(negedge clk); n++; end
    check("timeout_latency", cyc - t0, 32'd9);
    set_req(0, 1'b0, RD, 16'h0005, 16'h0000);
    mem_dead = 1'b0;

    // Normal service after the timeout.
    do_req(0, RD, 16'h0003, 16'h0000, 16'h0011, 1'b1, 1'b1);

    // Reset in the middle of BUSY.
    mem_dead = 1'b1;
    @(posedge clk); #1;
    set_req(0, 1'b1, WR, 16'h0020, 16'h1234);
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_if.EN && n < 50);
    @(posedge clk); #1;
    reset = 1'b1;
    set_req(0, 1'b0, WR, 16'h0020, 16'h1234);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mrst_mem_en", {31'd0, mem_if.EN}, 32'd0);
    check("mrst_gnt", {30'd0, gnt}, 32'd0);
    check("mrst_rdata", {16'd0, r0_if.rdata}, 32'd0);
    check("mrst_mem_addr", {16'd0, mem_if.addr}, 32'd0);
    check("mrst_mem_wdata", {16'd0, mem_if.wdata}, 32'd0);
    check("mrst_mem_rw", {31'd0, mem_if.RW}, 32'd0);
    check("mrst_mfc", {30'd0, r1_if.MFC, r0_if.MFC}, 32'd0);
    check("mrst_err", {31'd0, err}, 32'd0);
    repeat (12) @(negedge clk);
    mem_dead = 1'b0;
    do_req(1, RD, 16'h0010, 16'h0000, 16'hF0F0, 1'b1, 1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
